// File: rtl/gps_sv_scheduler_pkg.sv
// Shared types and width constants for the GPS satellite code-generator scheduler.
package gps_sched_pkg;

    localparam int unsigned SV_NUM_W        = 6;
    localparam int unsigned NUM_SV_DEF      = 32;
    localparam int unsigned CA_W_DEF        = 13;
    localparam int unsigned CODE_W_DEF      = 128;
    localparam int unsigned TIMEOUT_DEF     = 1024;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        DELIVER
    } state_t;

endpackage

// File: rtl/gps_sv_scheduler_pick.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit and whether any bit is set.
module gps_sched_pick #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] shifted;

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx     = '0;
        any     = |vec;
        shifted = '0;
        for (int unsigned i = N; i > 0; i--) begin
            shifted = vec >> (i - 1);
            if (shifted[0]) begin
                idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/gps_sv_scheduler.sv
// Walks an enable mask of PRNs, starts the shared code generator for each and hands the codes
// out on a valid/ready port. Optional WAIT watchdog: define GPS_SCHED_WATCHDOG_EN.
module gps_sv_scheduler
    import gps_sched_pkg::*;
#(
    parameter int unsigned NUM_SV         = NUM_SV_DEF,
    parameter int unsigned CA_W           = CA_W_DEF,
    parameter int unsigned CODE_W         = CODE_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                enable,
    input  logic [NUM_SV-1:0]   sv_mask,
    output logic [SV_NUM_W-1:0] gen_sv_num,
    output logic                gen_start,
    input  logic [CA_W-1:0]     gen_ca_code,
    input  logic [CODE_W-1:0]   gen_p_code,
    input  logic [CODE_W-1:0]   gen_l_code,
    input  logic                gen_l_code_valid,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [SV_NUM_W-1:0] res_sv,
    output logic [CA_W-1:0]     res_ca_code,
    output logic [CODE_W-1:0]   res_p_code,
    output logic [CODE_W-1:0]   res_l_code,
    output logic                res_timeout,
    output logic                busy,
    output logic                round_done
);

    localparam int unsigned IDX_W = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;

    state_t              state_q, state_d;
    logic [NUM_SV-1:0]   work_mask_q, work_mask_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SV_NUM_W-1:0] gen_sv_num_q, gen_sv_num_d;
    logic [SV_NUM_W-1:0] res_sv_q, res_sv_d;
    logic [CA_W-1:0]     res_ca_q, res_ca_d;
    logic [CODE_W-1:0]   res_p_q, res_p_d;
    logic [CODE_W-1:0]   res_l_q, res_l_d;
    logic                round_done_q, round_done_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NUM_SV-1:0]   mask_left;
    logic                wdog_expired;

    gps_sched_pick #(
        .N     (NUM_SV),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec (work_mask_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign mask_left = work_mask_q & ~(NUM_SV'(1) << idx_q);

    always_comb begin
        state_d      = state_q;
        work_mask_d  = work_mask_q;
        idx_d        = idx_q;
        gen_sv_num_d = gen_sv_num_q;
        res_sv_d     = res_sv_q;
        res_ca_d     = res_ca_q;
        res_p_d      = res_p_q;
        res_l_d      = res_l_q;
        round_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (|sv_mask)) begin
                    work_mask_d = sv_mask;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (pick_any) begin
                    idx_d        = pick_idx;
                    gen_sv_num_d = SV_NUM_W'(pick_idx) + SV_NUM_W'(1);
                    state_d      = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (gen_l_code_valid) begin
                    res_sv_d = gen_sv_num_q;
                    res_ca_d = gen_ca_code;
                    res_p_d  = gen_p_code;
                    res_l_d  = gen_l_code;
                    state_d  = DELIVER;
                end else if (wdog_expired) begin
                    res_sv_d = gen_sv_num_q;
                    res_ca_d = '0;
                    res_p_d  = '0;
                    res_l_d  = '0;
                    state_d  = DELIVER;
                end
            end
            DELIVER: begin
                // Dropping enable discards the rest of the round without a round_done.
                if (res_ready) begin
                    if (enable && (|mask_left)) begin
                        work_mask_d = mask_left;
                        state_d     = SELECT;
                    end else begin
                        work_mask_d  = '0;
                        round_done_d = ~(|mask_left);
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            work_mask_q  <= '0;
            idx_q        <= '0;
            gen_sv_num_q <= '0;
            res_sv_q     <= '0;
            res_ca_q     <= '0;
            res_p_q      <= '0;
            res_l_q      <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_mask_q  <= work_mask_d;
            idx_q        <= idx_d;
            gen_sv_num_q <= gen_sv_num_d;
            res_sv_q     <= res_sv_d;
            res_ca_q     <= res_ca_d;
            res_p_q      <= res_p_d;
            res_l_q      <= res_l_d;
            round_done_q <= round_done_d;
        end
    end

`ifdef GPS_SCHED_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             res_to_q, res_to_d;

    assign wdog_expired = (wdog_q == '0);

    // The flag is only rewritten in WAIT, so it stays stable alongside the DELIVER payload.
    always_comb begin
        wdog_d   = wdog_q;
        res_to_d = res_to_q;
        if (state_q == START) begin
            wdog_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == WAIT) begin
            res_to_d = ~gen_l_code_valid & wdog_expired;
            if (!wdog_expired) begin
                wdog_d = wdog_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            wdog_q   <= '0;
            res_to_q <= 1'b0;
        end else begin
            wdog_q   <= wdog_d;
            res_to_q <= res_to_d;
        end
    end

    assign res_timeout = res_to_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wdog_expired       = 1'b0;
    assign res_timeout        = 1'b0;
`endif

    assign gen_sv_num  = gen_sv_num_q;
    assign gen_start   = (state_q == START);
    assign res_valid   = (state_q == DELIVER);
    assign res_sv      = res_sv_q;
    assign res_ca_code = res_ca_q;
    assign res_p_code  = res_p_q;
    assign res_l_code  = res_l_q;
    assign busy        = (state_q != IDLE);
    assign round_done  = round_done_q;

endmodule

// File: tb/tb_gps_sv_scheduler.sv
// Directed plus randomized bench for gps_sv_scheduler; the generator is modelled in the bench.
module tb_gps_sv_scheduler;

    localparam int unsigned NUM_SV = 32;
    localparam int unsigned CA_W   = 13;
    localparam int unsigned CODE_W = 128;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              enable;
    logic [NUM_SV-1:0] sv_mask;
    logic [5:0]        gen_sv_num;
    logic              gen_start;
    logic [CA_W-1:0]   gen_ca_code;
    logic [CODE_W-1:0] gen_p_code;
    logic [CODE_W-1:0] gen_l_code;
    logic              gen_l_code_valid;
    logic              res_valid;
    logic              res_ready;
    logic [5:0]        res_sv;
    logic [CA_W-1:0]   res_ca_code;
    logic [CODE_W-1:0] res_p_code;
    logic [CODE_W-1:0] res_l_code;
    logic              res_timeout;
    logic              busy;
    logic              round_done;

    int checks = 0;
    int errors = 0;

    gps_sv_scheduler #(
        .NUM_SV         (NUM_SV),
        .CA_W           (CA_W),
        .CODE_W         (CODE_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .enable           (enable),
        .sv_mask          (sv_mask),
        .gen_sv_num       (gen_sv_num),
        .gen_start        (gen_start),
        .gen_ca_code      (gen_ca_code),
        .gen_p_code       (gen_p_code),
        .gen_l_code       (gen_l_code),
        .gen_l_code_valid (gen_l_code_valid),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_sv           (res_sv),
        .res_ca_code      (res_ca_code),
        .res_p_code       (res_p_code),
        .res_l_code       (res_l_code),
        .res_timeout      (res_timeout),
        .busy             (busy),
        .round_done       (round_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed time %0t expected finish earlier", $time);
        $fatal(1, "bench did not finish");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sv_num"}, gen_sv_num, 0);
        check({tag, "_start"}, gen_start, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_sv"}, res_sv, 0);
        check({tag, "_res_ca"}, res_ca_code, 0);
        check({tag, "_res_p"}, res_p_code, 0);
        check({tag, "_res_l"}, res_l_code, 0);
        check({tag, "_timeout"}, res_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_round_done"}, round_done, 0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (gen_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", gen_start, 1);
    endtask

    // One PRN through the scheduler: generator answers dly cycles after gen_start,
    // downstream stalls for hold cycles, then the post-handshake state is checked.
    task automatic run_prn(input int prn, input int dly, input int hold, input bit exp_idle,
                           input bit exp_done, input bit drop_en, input bit glitch);
        logic [CA_W-1:0]   ca;
        logic [CODE_W-1:0] p, l;
        ca = CA_W'($urandom);
        p  = rand128();
        l  = rand128();
        wait_start();
        check("start_sv_num", gen_sv_num, prn);
        if (glitch) begin
            gen_l_code_valid = 1'b1;
            gen_ca_code      = ~ca;
            gen_p_code       = ~p;
            gen_l_code       = ~l;
        end
        for (int i = 1; i <= dly; i++) begin
            @(negedge clk);
            if (i == 1 && drop_en) enable = 1'b0;
            check("wait_no_valid", res_valid, 0);
            check("wait_sv_num", gen_sv_num, prn);
            check("wait_no_start", gen_start, 0);
            gen_l_code_valid = (i == dly);
            gen_ca_code      = (i == dly) ? ca : CA_W'($urandom);
            gen_p_code       = (i == dly) ? p : rand128();
            gen_l_code       = (i == dly) ? l : rand128();
        end
        @(negedge clk);
        gen_l_code_valid = 1'b0;
        gen_ca_code      = CA_W'($urandom);
        gen_p_code       = rand128();
        gen_l_code       = rand128();
        check("res_valid", res_valid, 1);
        check("res_sv", res_sv, prn);
        check("res_ca", res_ca_code, ca);
        check("res_p", res_p_code, p);
        check("res_l", res_l_code, l);
        check("res_timeout", res_timeout, 0);
        if (hold > 0) begin
            res_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", res_valid, 1);
                check("hold_ca", res_ca_code, ca);
                check("hold_p", res_p_code, p);
                check("hold_l", res_l_code, l);
                check("hold_no_start", gen_start, 0);
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        check("post_valid", res_valid, 0);
        check("post_round_done", round_done, exp_done);
        check("post_busy", busy, !exp_idle);
    endtask

    // Reference: the visit order is the set bits of the latched mask in ascending PRN order.
    task automatic run_round(input logic [NUM_SV-1:0] m);
        int prns[$];
        for (int b = 0; b < NUM_SV; b++) if (m[b]) prns.push_back(b + 1);
        sv_mask = m;
        enable  = 1'b1;
        foreach (prns[j]) begin
            run_prn(prns[j], $urandom_range(1, 4), $urandom_range(0, 2),
                    j == prns.size() - 1, j == prns.size() - 1, 1'b0, 1'($urandom_range(0, 1)));
            if (j == prns.size() - 1) enable = 1'b0;
            else if (j == 0) sv_mask = $urandom;
        end
        @(negedge clk);
        check("round_idle_busy", busy, 0);
    endtask

    initial begin
        logic [NUM_SV-1:0] m;
        rst_in           = 1'b1;
        enable           = 1'b0;
        sv_mask          = '0;
        gen_ca_code      = '0;
        gen_p_code       = '0;
        gen_l_code       = '0;
        gen_l_code_valid = 1'b0;
        res_ready        = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Two back-to-back rounds of PRN 1,3; mask cleared mid second round.
        sv_mask = 32'h0000_0005;
        enable  = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        run_prn(1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_prn(3, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_prn(1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        sv_mask = '0;
        run_prn(3, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Empty mask with enable high stays idle.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("empty_no_start", gen_start, 0);
            check("empty_busy", busy, 0);
        end

        // Downstream stall on PRN 2.
        sv_mask = 32'h0000_0006;
        run_prn(2, 2, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        run_prn(3, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;

        // Enable dropped during PRN 1 WAIT: PRN 2 discarded, no round_done.
        @(negedge clk);
        sv_mask = 32'h0000_0003;
        enable  = 1'b1;
        run_prn(1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("drop_no_start", gen_start, 0);
            check("drop_busy", busy, 0);
            check("drop_no_done", round_done, 0);
        end

        // Asynchronous reset in WAIT, then the round restarts from PRN 1.
        enable = 1'b1;
        wait_start();
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        rst_in = 1'b0;
        run_prn(1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_prn(2, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        @(negedge clk);

        // Randomized rounds, first one exercising the top PRN.
        for (int r = 0; r < 6; r++) begin
            m = (r == 0) ? 32'h8000_0001 : ($urandom & $urandom & $urandom);
            if (m == '0) m[$urandom_range(0, NUM_SV - 1)] = 1'b1;
            run_round(m);
        end

`ifdef GPS_SCHED_WATCHDOG_EN
        // Silent generator on PRN 1: timeout result after 8 WAIT cycles, PRN 2 proceeds.
        sv_mask = 32'h0000_0003;
        enable  = 1'b1;
        wait_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wd_wait_no_valid", res_valid, 0);
        end
        @(negedge clk);
        check("wd_valid", res_valid, 1);
        check("wd_timeout", res_timeout, 1);
        check("wd_sv", res_sv, 1);
        check("wd_ca", res_ca_code, 0);
        check("wd_p", res_p_code, 0);
        check("wd_l", res_l_code, 0);
        @(negedge clk);
        check("wd_post_valid", res_valid, 0);
        check("wd_post_busy", busy, 1);
        run_prn(2, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
